intc: RTL and testbench
=======================

INTC -- requirements
Module: intc

Interface
REQ-001 Parameters: none; source count fixed at 8.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 AD  input  2  register select.
REQ-005 DI  input  8  write data.
REQ-006 DO  output  8  read data, combinational from AD.
REQ-007 rw  input  1  1 = read, 0 = write.
REQ-008 cs  input  1  chip select; write occurs on a clock edge with cs=1, rw=0.
REQ-009 src  input  8  interrupt sources; src[0] highest priority; timer intr wires to src[0].
REQ-010 irq  output  1  registered interrupt request to the CPU, active-high.

Function
REQ-011 Register map: $00 PEND (R: pending[7:0]; W: bits written 1 clear, bits written 0 unchanged); $01 MASK (R/W, 1 = enabled); $02 MODE (R/W, 1 = edge, 0 = level); $03 VEC (R: {irq, 4'b0, idx[2:0]}; W any value: ack).
REQ-012 Reads have no side effects.
REQ-013 Input stage: src registered once into src_q every edge (twice with INTC_SYNC_EN); prev <= src_q every edge.
REQ-014 Edge mode: pending[i] set on any edge where armed=1 and src_q[i] != prev[i]; rising and falling both count (toggle-style sources such as the timer).
REQ-015 Level mode: pending[i] set on every edge where src_q[i]=1; cleared only by PEND write or ack while src_q[i]=0.
REQ-016 Simultaneous set and clear of the same pending bit: set wins.
REQ-017 Pending bits latch independent of MASK; MASK gates only irq and idx.
REQ-018 active = pending & MASK; idx = lowest index i with active[i]=1, 0 if active=0.
REQ-019 irq <= |active every edge; one cycle after pending/MASK change.
REQ-020 Ack (write $03): clears pending[idx] only if active != 0; else no effect; DI ignored.
REQ-021 Latency without INTC_SYNC_EN: src change sampled at edge E -> pending set at E+1 -> irq high after E+2.
REQ-022 MODE change on an already-pending bit leaves pending unchanged.
REQ-023 Writes to $00-$02 with cs=1, rw=0 take effect at that edge; cs=0 blocks all writes and acks.

Reset
REQ-024 On rst=1 at an edge: pending, MASK, MODE, src_q, sync stages, prev, armed, irq all 0.
REQ-025 armed <= 1 on first edge with rst=0; edge detection suppressed while armed=0, so a source high at reset release causes no edge-mode pending.
REQ-026 Reset mid-operation discards all pending state; irq low the edge rst is sampled.

Configuration
REQ-027 Macro INTC_SYNC_EN defined: two-flop synchronizer on src before src_q; all src-to-irq latencies +1 cycle (irq after E+3).
REQ-028 INTC_SYNC_EN undefined: single register stage; src assumed synchronous to clk; latency per REQ-021.

Verification
REQ-029 Reset, MASK=$01, MODE=$01; src[0] 0->1 at edge E -> PEND reads $01 after E+1, irq=1 after E+2, VEC reads $80.
REQ-030 MASK=$FF, MODE=$FF; src[5] and src[2] toggle same cycle -> PEND=$24, VEC=$82; ack -> PEND=$20, VEC=$85; ack -> PEND=$00, irq=0 next cycle.
REQ-031 MODE=$00, MASK=$08; src[3] held 1 -> write PEND=$08 leaves PEND=$08, irq=1; src[3]=0 then write PEND=$08 -> PEND=$00, irq=0.
REQ-032 MASK=$00, MODE=$01; src[0] toggles -> PEND=$01, irq=0; write MASK=$01 -> irq=1 one cycle later; write to $03 with cs=0 -> PEND unchanged.
REQ-033 src=$FF held through reset, MODE set $FF after -> PEND stays $00 (armed suppression); src[7] 1->0 -> PEND=$80.
REQ-034 Edge-mode src[1] toggles on same edge as PEND write $02 -> PEND bit 1 remains set (set wins); repeat with INTC_SYNC_EN -> irq one cycle later than REQ-029 timing.

Source files
------------

// File: rtl/intc.sv
// -----------------------------------------------------------------------------
// intc -- eight-source interrupt controller with a four-register CPU port.
//
// Sources are sampled into src_q every clock. Each source can be in edge mode
// (pending on any change of src_q) or level mode (pending while src_q is high).
// Pending bits latch regardless of MASK. MASK only gates irq and the vector
// index. src[0] has the highest priority.
//
// Register map (AD):
//   0 PEND  R: pending[7:0]   W: 1 clears the bit, 0 leaves it
//   1 MASK  R/W, 1 = source enabled
//   2 MODE  R/W, 1 = edge, 0 = level
//   3 VEC   R: {irq, 4'b0, idx[2:0]}   W (any data): acknowledge the current idx
//
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous reset, active high
//   AD   register select
//   DI   write data
//   DO   read data, combinational from AD
//   rw   1 = read, 0 = write
//   cs   chip select; a write happens on an edge with cs=1 and rw=0
//   src  interrupt sources (timer on src[0])
//   irq  registered interrupt request, active high
//
// Build option: define INTC_SYNC_EN to insert a two-flop synchronizer in front
// of src_q for asynchronous sources. This adds one cycle of src-to-irq latency.
// -----------------------------------------------------------------------------
module intc (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] AD,
   input  logic [7:0] DI,
   output logic [7:0] DO,
   input  logic       rw,
   input  logic       cs,
   input  logic [7:0] src,
   output logic       irq
);

   typedef enum logic [1:0] {
      REG_PEND = 2'd0,
      REG_MASK = 2'd1,
      REG_MODE = 2'd2,
      REG_VEC  = 2'd3
   } reg_addr_e;

   logic [7:0] pending_q, pending_d;
   logic [7:0] mask_q, mask_d;
   logic [7:0] mode_q, mode_d;
   logic [7:0] src_q;
   logic [7:0] prev_q;
   logic       armed_q;
   logic       irq_q, irq_d;

   logic [7:0] src_in;
   logic [7:0] active;
   logic [2:0] idx;
   logic [7:0] edge_set;
   logic [7:0] level_set;
   logic [7:0] clr;
   logic       wr_en;

`ifdef INTC_SYNC_EN
   // First synchronizer flop. The second flop is src_q itself, so the
   // sample reaching the edge detector has passed two flops.
   logic [7:0] sync_q;

   always_ff @(posedge clk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= src;
   end

   assign src_in = sync_q;
`else
   assign src_in = src;
`endif

   // ---------------------------------------------------------------------------
   // Combinational decode and next state
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default before any conditional assignment,
      // so no path through this block leaves a value held (no latch).
      wr_en     = cs && !rw;
      active    = pending_q & mask_q;
      idx       = 3'd0;
      clr       = '0;
      mask_d    = mask_q;
      mode_d    = mode_q;

      // Scan from the top down so the lowest active index is the one kept.
      for (int i = 7; i >= 0; i--) begin
         if (active[i]) idx = 3'(i);
      end

      // Edges are ignored until the input pipeline has been seeded after reset.
      edge_set  = armed_q ? ((src_q ^ prev_q) & mode_q) : 8'h00;
      level_set = src_q & ~mode_q;

      if (wr_en) begin
         case (reg_addr_e'(AD))
            REG_PEND: clr = DI;
            REG_MASK: mask_d = DI;
            REG_MODE: mode_d = DI;
            REG_VEC:  if (active != 8'h00) clr[idx] = 1'b1;
            default:  ;
         endcase
      end

      // Set terms are OR-ed in after the clear so a simultaneous set wins.
      pending_d = (pending_q & ~clr) | edge_set | level_set;
      irq_d     = |active;
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
         mask_q    <= '0;
         mode_q    <= '0;
         src_q     <= '0;
         prev_q    <= '0;
         armed_q   <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         pending_q <= pending_d;
         mask_q    <= mask_d;
         mode_q    <= mode_d;
         irq_q     <= irq_d;
         armed_q   <= 1'b1;
         if (armed_q) begin
            src_q  <= src_in;
            prev_q <= src_q;
         end else begin
            // First edge out of reset: load src_q and prev_q straight from the
            // live sources so a source already high at release is not seen as
            // a 0->1 transition against the zeroed reset values.
            src_q  <= src;
            prev_q <= src;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Read mux (no side effects)
   // ---------------------------------------------------------------------------
   always_comb begin
      DO = 8'h00;
      case (reg_addr_e'(AD))
         REG_PEND: DO = pending_q;
         REG_MASK: DO = mask_q;
         REG_MODE: DO = mode_q;
         REG_VEC:  DO = {irq_q, 4'b0000, idx};
         default:  DO = 8'h00;
      endcase
   end

   assign irq = irq_q;

endmodule

// File: tb/tb_intc.sv
// -----------------------------------------------------------------------------
// tb_intc -- directed-vector bench for intc. Inputs change 1 ns after a rising
// edge; outputs are read a further 1 ns later, well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_intc;

`ifdef INTC_SYNC_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 0;
`endif

   logic       clk;
   logic       rst;
   logic [1:0] AD;
   logic [7:0] DI;
   logic [7:0] DO;
   logic       rw;
   logic       cs;
   logic [7:0] src;
   logic       irq;

   int vectors     = 0;
   int miscompares = 0;

   intc dut (
      .clk (clk),
      .rst (rst),
      .AD  (AD),
      .DI  (DI),
      .DO  (DO),
      .rw  (rw),
      .cs  (cs),
      .src (src),
      .irq (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %02h, expected %02h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      AD = a; DI = d; cs = 1'b1; rw = 1'b0;
      step();
      cs = 1'b0; rw = 1'b1; DI = 8'h00;
   endtask

   task automatic chk_reg(input string tag, input logic [1:0] a, input logic [7:0] exp);
      AD = a;
      #1;
      check(tag, DO, exp);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
   endtask

   initial begin
      rst = 1'b1; AD = 2'd0; DI = 8'h00; rw = 1'b1; cs = 1'b0; src = 8'h00;

      // Reset state
      step(); step();
      check("rst_irq", {7'b0, irq}, 8'h00);
      chk_reg("rst_pend", 2'd0, 8'h00);
      chk_reg("rst_mask", 2'd1, 8'h00);
      rst = 1'b0;
      step();

      // Edge on src[0]: pending one edge after sampling, irq one after that
      wr(2'd1, 8'h01);
      wr(2'd2, 8'h01);
      src = 8'h01;
      step();                       // edge E samples src
      repeat (LAT) step();
      chk_reg("t29_pend_E", 2'd0, 8'h00);
      step();                       // E+1
      chk_reg("t29_pend_E1", 2'd0, 8'h01);
      check("t29_irq_E1", {7'b0, irq}, 8'h00);
      step();                       // E+2
      check("t29_irq_E2", {7'b0, irq}, 8'h01);
      chk_reg("t29_vec", 2'd3, 8'h80);

      // Two simultaneous edges, priority and two acks
      src = 8'h00;
      do_reset();
      wr(2'd1, 8'hFF);
      wr(2'd2, 8'hFF);
      src = 8'h24;
      step();
      repeat (LAT) step();
      step(); step();
      chk_reg("t30_pend", 2'd0, 8'h24);
      chk_reg("t30_vec", 2'd3, 8'h82);
      wr(2'd3, 8'h5A);
      chk_reg("t30_pend_ack1", 2'd0, 8'h20);
      chk_reg("t30_vec_ack1", 2'd3, 8'h85);
      wr(2'd3, 8'h00);
      chk_reg("t30_pend_ack2", 2'd0, 8'h00);
      step();
      check("t30_irq_low", {7'b0, irq}, 8'h00);

      // Level mode: a clear while the source is high is overridden
      src = 8'h00;
      do_reset();
      wr(2'd2, 8'h00);
      wr(2'd1, 8'h08);
      src = 8'h08;
      step();
      repeat (LAT) step();
      step(); step();
      chk_reg("t31_pend_hi", 2'd0, 8'h08);
      check("t31_irq_hi", {7'b0, irq}, 8'h01);
      wr(2'd0, 8'h08);
      chk_reg("t31_pend_held", 2'd0, 8'h08);
      check("t31_irq_held", {7'b0, irq}, 8'h01);
      src = 8'h00;
      step();
      repeat (LAT) step();
      wr(2'd0, 8'h08);
      chk_reg("t31_pend_clr", 2'd0, 8'h00);
      step();
      check("t31_irq_clr", {7'b0, irq}, 8'h00);

      // Pending latches while masked; unmasking raises irq one cycle later;
      // a write with cs=0 is ignored
      do_reset();
      wr(2'd1, 8'h00);
      wr(2'd2, 8'h01);
      src = 8'h01;
      step();
      repeat (LAT) step();
      step(); step();
      chk_reg("t32_pend", 2'd0, 8'h01);
      check("t32_irq_masked", {7'b0, irq}, 8'h00);
      wr(2'd1, 8'h01);
      check("t32_irq_same", {7'b0, irq}, 8'h00);
      step();
      check("t32_irq_next", {7'b0, irq}, 8'h01);
      AD = 2'd3; DI = 8'hFF; cs = 1'b0; rw = 1'b0;
      step();
      rw = 1'b1;
      chk_reg("t32_pend_nocs", 2'd0, 8'h01);
      check("t32_irq_nocs", {7'b0, irq}, 8'h01);

      // Sources high through reset: no edge-mode pending; falling edge counts
      src = 8'hFF;
      rst = 1'b1;
      step(); step();
      check("t33_rst_irq", {7'b0, irq}, 8'h00);
      chk_reg("t33_rst_pend", 2'd0, 8'h00);
      rst = 1'b0;
      AD = 2'd2; DI = 8'hFF; cs = 1'b1; rw = 1'b0;
      step();                       // first edge out of reset, MODE written
      cs = 1'b0; rw = 1'b1;
      step(); step(); step();
      chk_reg("t33_pend_armed", 2'd0, 8'h00);
      src = 8'h7F;
      step();
      repeat (LAT) step();
      step();
      chk_reg("t33_pend_fall", 2'd0, 8'h80);

      // Set wins over a PEND clear on the same edge
      src = 8'h00;
      do_reset();
      wr(2'd2, 8'h02);
      wr(2'd1, 8'h02);
      src = 8'h02;
      step();
      repeat (LAT) step();
      chk_reg("t34_pend_before", 2'd0, 8'h00);
      wr(2'd0, 8'h02);              // same edge that sets pending[1]
      chk_reg("t34_pend_setwins", 2'd0, 8'h02);
      check("t34_irq_same", {7'b0, irq}, 8'h00);
      step();
      check("t34_irq_next", {7'b0, irq}, 8'h01);

      // Reset mid-operation discards state and drops irq at that edge
      rst = 1'b1;
      step();
      check("t26_irq", {7'b0, irq}, 8'h00);
      chk_reg("t26_pend", 2'd0, 8'h00);
      chk_reg("t26_mode", 2'd2, 8'h00);
      rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
